// File: rtl/gsensor_spi_byte_engine.sv
// Byte-level SPI mode-3 master (CPOL=1, CPHA=1, MSB first) for the ADXL345 G-sensor.
// One byte per start/done handshake; CS is held low between bytes until a byte with last=1.
module gsensor_spi_byte_engine #(
  parameter int CLK_DIV = 4  // SCLK half-period in clk cycles, legal 2..255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       last,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] HC_MAX = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] hc_q, hc_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] rx_q, rx_d;
  logic       last_q, last_d;
  logic       cs_n_q, cs_n_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       hc_wrap;

  assign hc_wrap = (hc_q == HC_MAX);

  always_comb begin
    state_d = state_q;
    hc_d    = hc_wrap ? 8'd0 : hc_q + 8'd1;
    bit_d   = bit_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    rx_d    = rx_q;
    last_d  = last_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        hc_d  = 8'd0;
        bit_d = 3'd0;
        // busy_q is still high in the done cycle of a last=0 byte
        if (start && !busy_q) begin
          tx_sr_d = tx_data;
          last_d  = last;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b1;
          mosi_d  = tx_data[7];
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (hc_wrap) begin
          sclk_d  = 1'b0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (hc_wrap) begin
          if (!sclk_q) begin
            // rising edge: MISO is captured on the same clk edge that raises SCLK
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr_q[6:0], spi_miso};
            if (bit_q == 3'd7) begin
              if (last_q) begin
                state_d = S_HOLD;
              end else begin
                rx_d    = {rx_sr_q[6:0], spi_miso};
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            end
          end else begin
            sclk_d  = 1'b0;
            bit_d   = bit_q + 3'd1;
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
            mosi_d  = tx_sr_q[6];
          end
        end
      end

      S_HOLD: begin
        if (hc_wrap) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          rx_d    = rx_sr_q;
          done_d  = 1'b1;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (hc_wrap) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || done_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      hc_q    <= 8'd0;
      bit_q   <= 3'd0;
      tx_sr_q <= 8'd0;
      rx_sr_q <= 8'd0;
      rx_q    <= 8'd0;
      last_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      bit_q   <= bit_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      rx_q    <= rx_d;
      last_q  <= last_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_gsensor_spi_byte_engine.sv
// Directed bench for gsensor_spi_byte_engine: one instance at CLK_DIV=4, one at CLK_DIV=2,
// each with a queue-fed mode-3 slave that shifts out on SCLK falls and returns 0x00 once empty.
module tb_gsensor_spi_byte_engine;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start4 = 1'b0, last4 = 1'b0, start2 = 1'b0, last2 = 1'b0;
  logic [7:0] tx4 = 8'h00, tx2 = 8'h00;
  logic       busy4, done4, cs4, sclk4, mosi4;
  logic       busy2, done2, cs2, sclk2, mosi2;
  logic       miso4 = 1'b0, miso2 = 1'b0;
  logic [7:0] rx4, rx2;

  int checks = 0;
  int failures = 0;

  logic [7:0] q4[$];
  logic [7:0] q2[$];
  logic [7:0] sr4 = 8'h00, sr2 = 8'h00;
  int         cnt4 = 0, cnt2 = 0;

  bit sel = 1'b0;  // 0 selects the CLK_DIV=4 instance, 1 the CLK_DIV=2 instance

  gsensor_spi_byte_engine #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .tx_data(tx4), .last(last4),
    .busy(busy4), .done(done4), .rx_data(rx4), .spi_cs_n(cs4), .spi_sclk(sclk4),
    .spi_mosi(mosi4), .spi_miso(miso4)
  );

  gsensor_spi_byte_engine #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .tx_data(tx2), .last(last2),
    .busy(busy2), .done(done2), .rx_data(rx2), .spi_cs_n(cs2), .spi_sclk(sclk2),
    .spi_mosi(mosi2), .spi_miso(miso2)
  );

  always #5 clk = ~clk;

  // slave models: a new byte is fetched on the first fall after CS low or after 8 bits
  always @(negedge sclk4 or posedge cs4) begin
    if (cs4 === 1'b1) begin
      cnt4 = 0;
    end else if (sclk4 === 1'b0) begin
      if (cnt4 == 0) sr4 = (q4.size() > 0) ? q4.pop_front() : 8'h00;
      miso4 = sr4[7];
      sr4   = {sr4[6:0], 1'b0};
      cnt4  = (cnt4 + 1) % 8;
    end
  end

  always @(negedge sclk2 or posedge cs2) begin
    if (cs2 === 1'b1) begin
      cnt2 = 0;
    end else if (sclk2 === 1'b0) begin
      if (cnt2 == 0) sr2 = (q2.size() > 0) ? q2.pop_front() : 8'h00;
      miso2 = sr2[7];
      sr2   = {sr2[6:0], 1'b0};
      cnt2  = (cnt2 + 1) % 8;
    end
  end

  wire       m_busy = sel ? busy2 : busy4;
  wire       m_done = sel ? done2 : done4;
  wire       m_cs   = sel ? cs2 : cs4;
  wire       m_sclk = sel ? sclk2 : sclk4;
  wire       m_mosi = sel ? mosi2 : mosi4;
  wire [7:0] m_rx   = sel ? rx2 : rx4;

  typedef struct {
    int         d_cyc;
    int         csh;
    int         bl;
    int         rises;
    int         dcnt;
    int         lo_min, lo_max, hi_min, hi_max;
    logic [7:0] mosi_b;
    logic [7:0] rx_d;
    bit         unstable;
  } res_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit s, input logic st, input logic [7:0] tx, input logic l);
    if (s) begin
      start2 = st; tx2 = tx; last2 = l;
    end else begin
      start4 = st; tx4 = tx; last4 = l;
    end
  endtask

  // Called at a negedge: that clk cycle is cycle 0. Returns after the first busy=0 cycle.
  task automatic run_byte(input bit s, input logic [7:0] tx, input logic l, input int ncyc,
                          input bit poke, output res_t r);
    logic prev_sclk, prev_mosi;
    int   run;
    bit   after_rise;
    r.d_cyc = -1; r.csh = -1; r.bl = -1; r.rises = 0; r.dcnt = 0;
    r.lo_min = 999; r.lo_max = 0; r.hi_min = 999; r.hi_max = 0;
    r.mosi_b = 8'h00; r.rx_d = 8'h00; r.unstable = 1'b0;
    sel = s;
    set_in(s, 1'b1, tx, l);
    prev_sclk = 1'b1; prev_mosi = 1'b0; run = 0; after_rise = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      // mid-byte changes of tx_data/last and stray starts must be ignored
      set_in(s, poke && (c == 5 || c == 20 || c == 40), ~tx, ~l);
      if (after_rise && m_mosi !== prev_mosi) r.unstable = 1'b1;
      after_rise = 1'b0;
      if (m_sclk !== prev_sclk) begin
        if (m_sclk === 1'b1) begin
          r.rises++;
          r.mosi_b = {r.mosi_b[6:0], m_mosi};
          if (m_mosi !== prev_mosi) r.unstable = 1'b1;
          after_rise = 1'b1;
          if (run < r.lo_min) r.lo_min = run;
          if (run > r.lo_max) r.lo_max = run;
        end else begin
          if (run < r.hi_min) r.hi_min = run;
          if (run > r.hi_max) r.hi_max = run;
        end
        run = 1;
      end else begin
        run++;
      end
      if (m_done === 1'b1) begin
        r.dcnt++;
        if (r.d_cyc < 0) begin
          r.d_cyc = c;
          r.rx_d  = m_rx;
        end
      end
      if (m_cs === 1'b1 && r.csh < 0) r.csh = c;
      if (m_busy === 1'b0 && r.bl < 0) r.bl = c;
      prev_sclk = m_sclk;
      prev_mosi = m_mosi;
      if (r.bl > 0) break;
    end
  endtask

  initial begin
    res_t r, r1, r2;
    int   dcnt;

    q4 = '{8'h55, 8'h3C, 8'h00, 8'hF1, 8'h96};
    q2 = '{8'hFF};

    // reset held for 3 cycles
    repeat (3) @(negedge clk);
    chk("rst_cs", cs4, 1'b1);
    chk("rst_sclk", sclk4, 1'b1);
    chk("rst_mosi", mosi4, 1'b0);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0);
    chk("rst_rx", rx4, 8'h00);
    chk("rst_cs_div2", cs2, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_outs", {cs4, sclk4, mosi4, busy4, done4, rx4}, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

    // reset at cycle 30 of a transfer
    start4 = 1'b1; tx4 = 8'h55; last4 = 1'b1;
    dcnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4 === 1'b1) dcnt++;
    end
    chk("abort_cs_low", cs4, 1'b0);
    chk("abort_busy_before", busy4, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_cs", cs4, 1'b1);
    chk("abort_sclk", sclk4, 1'b1);
    chk("abort_busy", busy4, 1'b0);
    chk("abort_rx", rx4, 8'h00);
    chk("abort_no_done", dcnt + int'(done4), 0);
    // start sampled together with reset must be dropped
    start4 = 1'b1; tx4 = 8'hA5; last4 = 1'b1;
    @(negedge clk);
    reset_n = 1'b1; start4 = 1'b0;
    chk("rst_start_busy", busy4, 1'b0);
    chk("rst_start_cs", cs4, 1'b1);

    // single byte, CLK_DIV=4
    run_byte(1'b0, 8'hA5, 1'b1, 100, 1'b0, r);
    chk("single_done_cyc", r.d_cyc, 69);
    chk("single_rx", r.rx_d, 8'h3C);
    chk("single_cs_high_cyc", r.csh, 69);
    chk("single_busy_low_cyc", r.bl, 73);
    chk("single_mosi", r.mosi_b, 8'hA5);
    chk("single_rises", r.rises, 8);
    chk("single_mosi_stable", r.unstable, 1'b0);
    chk("single_done_cnt", r.dcnt, 1);
    chk("single_seg", {r.lo_min, r.hi_max}, {32'd4, 32'd4});

    // register read: 0xB2 (last=0) then 0x00 (last=1), started in first idle cycle
    run_byte(1'b0, 8'hB2, 1'b0, 100, 1'b0, r1);
    run_byte(1'b0, 8'h00, 1'b1, 100, 1'b0, r2);
    chk("rd1_done_cyc", r1.d_cyc, 65);
    chk("rd1_rx", r1.rx_d, 8'h00);
    chk("rd1_busy_low_cyc", r1.bl, 66);
    chk("rd1_cs_stays_low", r1.csh, -1);
    chk("rd1_mosi", r1.mosi_b, 8'hB2);
    chk("rd2_done_cyc", r2.d_cyc, 69);
    chk("rd2_rx", r2.rx_d, 8'hF1);
    chk("rd2_cs_high_cyc", r2.csh, 69);
    chk("rd2_mosi", r2.mosi_b, 8'h00);
    chk("rd_done_total", r1.dcnt + r2.dcnt, 2);

    // stray starts at cycles 5, 20, 40
    run_byte(1'b0, 8'h3C, 1'b1, 100, 1'b1, r);
    chk("ign_done_cnt", r.dcnt, 1);
    chk("ign_done_cyc", r.d_cyc, 69);
    chk("ign_rx", r.rx_d, 8'h96);
    chk("ign_mosi", r.mosi_b, 8'h3C);
    chk("ign_busy_low_cyc", r.bl, 73);
    repeat (3) @(negedge clk);
    chk("ign_no_requeue", busy4, 1'b0);

    // CLK_DIV=2
    @(negedge clk);
    run_byte(1'b1, 8'h5A, 1'b1, 60, 1'b0, r);
    chk("div2_done_cyc", r.d_cyc, 35);
    chk("div2_rx", r.rx_d, 8'hFF);
    chk("div2_busy_low_cyc", r.bl, 37);
    chk("div2_mosi", r.mosi_b, 8'h5A);
    chk("div2_lo_seg", {r.lo_min, r.lo_max}, {32'd2, 32'd2});
    chk("div2_hi_seg", {r.hi_min, r.hi_max}, {32'd2, 32'd2});
    run_byte(1'b1, 8'h81, 1'b1, 60, 1'b0, r);
    chk("div2_eof_rx", r.rx_d, 8'h00);
    chk("div2_eof_done_cyc", r.d_cyc, 35);
    chk("div2_eof_mosi", r.mosi_b, 8'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
